// File: rtl/sha256_arbiter_pkg.sv
// Shared constants, FSM encoding and the rotating priority search used by the
// sha256 core arbiter.
package sha256_arbiter_pkg;

    localparam int DEF_KEY_LEN   = 256;
    localparam int DEF_BLOCK_LEN = 1024;
    localparam int MAX_REQ       = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       any;
        logic [2:0] sel;
    } rr_result_t;

    // First set bit of req, scanning ptr, ptr+1, ... wrapping at num.
    function automatic rr_result_t rr_select(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 num
    );
        rr_result_t res;
        logic [3:0] idx;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(num)) begin
                idx = idx - 4'(num);
            end
            if (k < num && !res.any && req[idx[2:0]]) begin
                res.any = 1'b1;
                res.sel = idx[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sha256_arbiter_rr_enc.sv
// Rotating priority encoder: picks the next requester at or after the
// round-robin pointer.
module rr_priority_enc
    import sha256_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GW      = 3
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GW-1:0]      i_rr_ptr,
    output logic [GW-1:0]      o_sel,
    output logic               o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [2:0]         w_ptr;
    rr_result_t         w_res;

    assign w_req_ext = MAX_REQ'(i_req);
    assign w_ptr     = 3'(i_rr_ptr);
    assign w_res     = rr_select(w_req_ext, w_ptr, NUM_REQ);
    assign o_sel     = GW'(w_res.sel);
    assign o_any     = w_res.any;

endmodule

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256 core among NUM_REQ hash clients;
// each grant is held for one full hash and the done pulse goes to its owner.
module sha256_arbiter
    import sha256_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int KEY_LEN   = DEF_KEY_LEN,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN,
    parameter int GW        = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_hash_start,
    input  logic [NUM_REQ*BLOCK_LEN-1:0]   req_hash_data_in,
    input  logic [NUM_REQ-1:0]             req_message_length,
    output logic [NUM_REQ-1:0]             req_hash_done,
    output logic [KEY_LEN-1:0]             req_hash_data_out,
    output logic                           core_hash_start,
    output logic [BLOCK_LEN-1:0]           core_hash_data_in,
    output logic                           core_message_length,
    input  logic                           core_hash_done,
    input  logic [KEY_LEN-1:0]             core_hash_data_out,
    output logic                           busy,
    output logic [GW-1:0]                  grant_id,
    output logic                           err_overrun
);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_pending;
    logic [GW-1:0]      r_grant_id;
    logic [GW-1:0]      r_rr_ptr;
    logic               r_core_start;
    logic               r_busy;
    logic               r_err_overrun;

    logic [NUM_REQ-1:0] w_eff_req;
    logic [NUM_REQ-1:0] w_grant_onehot;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [NUM_REQ-1:0] w_overrun;
    logic [GW-1:0]      w_sel;
    logic [GW-1:0]      w_next_ptr;
    logic               w_any;
    logic               w_waiting;

    // A start seen while idle is granted on the same edge it is latched.
    assign w_eff_req = r_pending | req_hash_start;
    assign w_waiting = (r_state == ST_WAIT);

    rr_priority_enc #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_enc (
        .i_req    (w_eff_req),
        .i_rr_ptr (r_rr_ptr),
        .o_sel    (w_sel),
        .o_any    (w_any)
    );

    assign w_next_ptr = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + GW'(1);

    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_grant_onehot      = '0;
        w_sel_onehot        = '0;
        w_overrun           = '0;
        req_hash_done       = '0;
        core_hash_data_in   = '0;
        core_message_length = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_onehot[i] = (r_grant_id == GW'(i));
            w_sel_onehot[i]   = (w_sel == GW'(i));
            w_overrun[i]      = req_hash_start[i] &
                                (r_pending[i] | (w_waiting & (r_grant_id == GW'(i))));
            req_hash_done[i]  = core_hash_done & w_waiting & (r_grant_id == GW'(i));
            if (r_grant_id == GW'(i)) begin
                core_hash_data_in   = req_hash_data_in[i*BLOCK_LEN +: BLOCK_LEN];
                core_message_length = req_message_length[i];
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_core_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_overrun <= r_err_overrun | (|w_overrun);
            r_core_start  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id   <= w_sel;
                        r_pending    <= w_eff_req & ~w_sel_onehot;
                        r_core_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_WAIT;
                    end else begin
                        r_pending    <= w_eff_req;
                    end
                end
                ST_WAIT: begin
                    // A restart from the owner during its own hash is absorbed.
                    r_pending <= r_pending | (req_hash_start & ~w_grant_onehot);
                    if (core_hash_done) begin
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_hash_data_out = core_hash_data_out;
    assign core_hash_start   = r_core_start;
    assign busy              = r_busy;
    assign grant_id          = r_grant_id;
    assign err_overrun       = r_err_overrun;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Self-checking bench for sha256_arbiter: directed scenarios plus a randomized
// run against a queue-level round-robin reference model and a toy core.
module tb_sha256_arbiter;

    localparam int N  = 2;
    localparam int KL = 256;
    localparam int BL = 1024;
    localparam int GW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_hash_start;
    logic [N*BL-1:0] req_hash_data_in;
    logic [N-1:0]    req_message_length;
    logic [N-1:0]    req_hash_done;
    logic [KL-1:0]   req_hash_data_out;
    logic            core_hash_start;
    logic [BL-1:0]   core_hash_data_in;
    logic            core_message_length;
    logic            core_hash_done;
    logic [KL-1:0]   core_hash_data_out;
    logic            busy;
    logic [GW-1:0]   grant_id;
    logic            err_overrun;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sha256_arbiter #(
        .NUM_REQ   (N),
        .KEY_LEN   (KL),
        .BLOCK_LEN (BL),
        .GW        (GW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_hash_start      (req_hash_start),
        .req_hash_data_in    (req_hash_data_in),
        .req_message_length  (req_message_length),
        .req_hash_done       (req_hash_done),
        .req_hash_data_out   (req_hash_data_out),
        .core_hash_start     (core_hash_start),
        .core_hash_data_in   (core_hash_data_in),
        .core_message_length (core_message_length),
        .core_hash_done      (core_hash_done),
        .core_hash_data_out  (core_hash_data_out),
        .busy                (busy),
        .grant_id            (grant_id),
        .err_overrun         (err_overrun)
    );

    // Toy digest standing in for the real sha256 core.
    function automatic logic [KL-1:0] fold(input logic [BL-1:0] d, input logic len);
        return d[255:0] ^ d[511:256] ^ d[767:512] ^ d[1023:768] ^ {255'b0, len};
    endfunction

    function automatic logic [BL-1:0] rand_block();
        logic [BL-1:0] b;
        for (int w = 0; w < BL / 32; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    // Round-robin rule: first waiting client at or after rr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] waiting, input int rr);
        for (int k = 0; k < N; k++) begin
            if (waiting[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_client(input int i, input logic [BL-1:0] d, input logic len);
        req_hash_data_in[i*BL +: BL] = d;
        req_message_length[i]        = len;
    endtask

    // Each window: inputs change 2ns after the edge, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #2;
        req_hash_start = '0;
        core_hash_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (grant_id !== 3'd0) $display("FAIL reset_grant: got %0d want 0", grant_id); else n_pass++;
        n_total++; if (core_hash_start !== 1'b0) $display("FAIL reset_core_start: got %b want 0", core_hash_start); else n_pass++;
        n_total++; if (err_overrun !== 1'b0) $display("FAIL reset_err: got %b want 0", err_overrun); else n_pass++;
        n_total++; if (req_hash_done !== 2'b00) $display("FAIL reset_done: got %b want 00", req_hash_done); else n_pass++;
    endtask

    task automatic test_single_client();
        logic [BL-1:0] d0;
        logic [KL-1:0] dig;
        int bad;
        do_reset();
        d0  = rand_block();
        bad = 0;
        set_client(0, d0, 1'b0);
        for (int t = 1; t < 10; t++) step();
        req_hash_start = 2'b01;                 // cycle 10
        step();                                 // cycle 11
        n_total++; if (core_hash_start !== 1'b1) $display("FAIL single_start_latency: got %b want 1", core_hash_start); else n_pass++;
        n_total++; if (grant_id !== 3'd0) $display("FAIL single_grant: got %0d want 0", grant_id); else n_pass++;
        n_total++; if (core_hash_data_in !== d0) $display("FAIL single_data_in: got %h want %h", core_hash_data_in[63:0], d0[63:0]); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy_on: got %b want 1", busy); else n_pass++;
        for (int t = 12; t < 80; t++) begin
            step();
            #1;
            if (busy !== 1'b1 || core_hash_start !== 1'b0 || req_hash_done !== 2'b00) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL single_hold: got %0d bad cycles want 0", bad); else n_pass++;
        step();                                 // cycle 80
        dig                = fold(d0, 1'b0);
        core_hash_data_out = dig;
        core_hash_done     = 1'b1;
        #1;
        n_total++; if (req_hash_done !== 2'b01) $display("FAIL single_done_route: got %b want 01", req_hash_done); else n_pass++;
        n_total++; if (req_hash_data_out !== dig) $display("FAIL single_digest: got %h want %h", req_hash_data_out[63:0], dig[63:0]); else n_pass++;
        step();                                 // cycle 81
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL single_busy_off: got %b want 0", busy); else n_pass++;
        // A done pulse while idle must be ignored.
        core_hash_done = 1'b1;
        #1;
        n_total++; if (req_hash_done !== 2'b00) $display("FAIL idle_done_ignored: got %b want 00", req_hash_done); else n_pass++;
        step();
        n_total++; if (busy !== 1'b0 || core_hash_start !== 1'b0) $display("FAIL idle_done_no_start: got busy=%b start=%b want 0 0", busy, core_hash_start); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [BL-1:0] d0, d1;
        do_reset();
        d0 = rand_block();
        d1 = rand_block();
        set_client(0, d0, 1'b0);
        set_client(1, d1, 1'b1);
        req_hash_start = 2'b11;
        step();
        n_total++; if (grant_id !== 3'd0 || core_hash_start !== 1'b1) $display("FAIL simul_first: got grant=%0d start=%b want 0 1", grant_id, core_hash_start); else n_pass++;
        step();
        step();
        core_hash_data_out = fold(d0, 1'b0);
        core_hash_done     = 1'b1;
        #1;
        n_total++; if (req_hash_done !== 2'b01) $display("FAIL simul_done0: got %b want 01", req_hash_done); else n_pass++;
        step();
        n_total++; if (core_hash_start !== 1'b0 || busy !== 1'b0) $display("FAIL simul_gap: got start=%b busy=%b want 0 0", core_hash_start, busy); else n_pass++;
        step();
        n_total++; if (grant_id !== 3'd1 || core_hash_start !== 1'b1) $display("FAIL simul_second: got grant=%0d start=%b want 1 1", grant_id, core_hash_start); else n_pass++;
        n_total++; if (core_hash_data_in !== d1 || core_message_length !== 1'b1) $display("FAIL simul_mux1: got len=%b data=%h want 1 %h", core_message_length, core_hash_data_in[63:0], d1[63:0]); else n_pass++;
        step();
        core_hash_data_out = fold(d1, 1'b1);
        core_hash_done     = 1'b1;
        #1;
        n_total++; if (req_hash_done !== 2'b10) $display("FAIL simul_done1: got %b want 10", req_hash_done); else n_pass++;
        step();
        req_hash_start = 2'b11;                 // rr pointer should be back at 0
        step();
        n_total++; if (grant_id !== 3'd0) $display("FAIL simul_rr_wrap: got %0d want 0", grant_id); else n_pass++;
    endtask

    task automatic test_fairness();
        int bad, cnt0, cnt1;
        do_reset();
        bad  = 0;
        cnt0 = 0;
        cnt1 = 0;
        set_client(0, rand_block(), 1'b0);
        set_client(1, rand_block(), 1'b0);
        req_hash_start = 2'b11;
        for (int k = 0; k < 20; k++) begin
            step();
            if (core_hash_start !== 1'b1 || grant_id !== 3'(k % 2)) bad++;
            step();
            step();
            core_hash_data_out = {8{$urandom}};
            core_hash_done     = 1'b1;
            #1;
            if (req_hash_done[0] === 1'b1) cnt0++;
            if (req_hash_done[1] === 1'b1) cnt1++;
            step();
            req_hash_start[k % 2] = 1'b1;       // served client restarts immediately
        end
        n_total++; if (bad != 0) $display("FAIL fair_alternation: got %0d bad grants want 0", bad); else n_pass++;
        n_total++; if (cnt0 != 10) $display("FAIL fair_count0: got %0d want 10", cnt0); else n_pass++;
        n_total++; if (cnt1 != 10) $display("FAIL fair_count1: got %0d want 10", cnt1); else n_pass++;
    endtask

    task automatic test_thash_sequence();
        logic [KL-1:0] prev, dig;
        logic [BL-1:0] d;
        logic          lens [4];
        lens = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        set_client(0, '0, 1'b0);
        prev = '0;
        for (int h = 0; h < 4; h++) begin
            d = rand_block();
            d[255:0] = prev;                    // chain the previous digest in
            set_client(1, d, lens[h]);
            req_hash_start = 2'b10;
            step();
            n_total++; if (core_hash_start !== 1'b1 || grant_id !== 3'd1) $display("FAIL thash_grant%0d: got start=%b grant=%0d want 1 1", h, core_hash_start, grant_id); else n_pass++;
            n_total++; if (core_message_length !== lens[h]) $display("FAIL thash_len%0d: got %b want %b", h, core_message_length, lens[h]); else n_pass++;
            n_total++; if (core_hash_data_in !== d) $display("FAIL thash_data%0d: got %h want %h", h, core_hash_data_in[63:0], d[63:0]); else n_pass++;
            step();
            dig                = fold(d, lens[h]);
            core_hash_data_out = dig;
            core_hash_done     = 1'b1;
            #1;
            n_total++; if (req_hash_done !== 2'b10 || req_hash_data_out !== dig) $display("FAIL thash_done%0d: got done=%b dig=%h want 10 %h", h, req_hash_done, req_hash_data_out[63:0], dig[63:0]); else n_pass++;
            prev = dig;
            step();
        end
    endtask

    task automatic test_overrun();
        do_reset();
        set_client(0, rand_block(), 1'b0);
        set_client(1, rand_block(), 1'b1);
        req_hash_start = 2'b01;
        step();                                 // client0 granted
        #1;
        n_total++; if (err_overrun !== 1'b0) $display("FAIL overrun_clean: got %b want 0", err_overrun); else n_pass++;
        req_hash_start = 2'b11;                 // client0 restarts while granted
        step();
        n_total++; if (err_overrun !== 1'b1) $display("FAIL overrun_granted: got %b want 1", err_overrun); else n_pass++;
        req_hash_start = 2'b10;                 // client1 restarts while pending
        step();
        core_hash_done = 1'b1;
        #1;
        n_total++; if (req_hash_done !== 2'b01) $display("FAIL overrun_done0: got %b want 01", req_hash_done); else n_pass++;
        step();
        step();
        n_total++; if (core_hash_start !== 1'b1 || grant_id !== 3'd1) $display("FAIL overrun_serve1: got start=%b grant=%0d want 1 1", core_hash_start, grant_id); else n_pass++;
        step();
        core_hash_done = 1'b1;
        #1;
        n_total++; if (req_hash_done !== 2'b10) $display("FAIL overrun_done1: got %b want 10", req_hash_done); else n_pass++;
        step();
        step();
        n_total++; if (busy !== 1'b0 || core_hash_start !== 1'b0) $display("FAIL overrun_single_issue: got busy=%b start=%b want 0 0", busy, core_hash_start); else n_pass++;
        n_total++; if (err_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", err_overrun); else n_pass++;
        do_reset();
        n_total++; if (err_overrun !== 1'b0) $display("FAIL overrun_reset_clear: got %b want 0", err_overrun); else n_pass++;
    endtask

    task automatic test_reset_mid_hash();
        do_reset();
        set_client(0, rand_block(), 1'b0);
        set_client(1, rand_block(), 1'b0);
        req_hash_start = 2'b01;
        step();                                 // WAIT cycle 1
        req_hash_start = 2'b10;                 // client1 left pending
        step();
        step();
        step();
        step();                                 // WAIT cycle 5
        reset = 1'b1;
        step();
        reset          = 1'b0;
        core_hash_done = 1'b1;                  // stray done right after reset
        #1;
        n_total++; if (busy !== 1'b0 || core_hash_start !== 1'b0) $display("FAIL midreset_state: got busy=%b start=%b want 0 0", busy, core_hash_start); else n_pass++;
        n_total++; if (req_hash_done !== 2'b00) $display("FAIL midreset_no_done: got %b want 00", req_hash_done); else n_pass++;
        step();
        n_total++; if (busy !== 1'b0) $display("FAIL midreset_pending_cleared: got busy=%b want 0", busy); else n_pass++;
        req_hash_start = 2'b11;
        step();
        n_total++; if (core_hash_start !== 1'b1 || grant_id !== 3'd0) $display("FAIL midreset_restart: got start=%b grant=%0d want 1 0", core_hash_start, grant_id); else n_pass++;
    endtask

    task automatic test_random();
        logic          active [N];
        int            starts [N];
        int            dones  [N];
        logic [BL-1:0] cdata  [N];
        logic          clen   [N];
        logic [N-1:0]  m_wait;
        logic [N-1:0]  s, exp_done;
        logic          m_busy, m_expect_start, d;
        int            m_grant, m_rr, lat, p;
        int            bad_start, bad_busy, bad_done, bad_dig, bad_cnt;
        do_reset();
        m_wait = '0; m_busy = 1'b0; m_expect_start = 1'b0;
        m_grant = 0; m_rr = 0; lat = 0;
        bad_start = 0; bad_busy = 0; bad_done = 0; bad_dig = 0; bad_cnt = 0;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0; starts[i] = 0; dones[i] = 0;
            cdata[i] = '0; clen[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            if (m_expect_start) begin
                if (core_hash_start !== 1'b1 || grant_id !== GW'(m_grant) ||
                    core_hash_data_in !== cdata[m_grant] || core_message_length !== clen[m_grant]) bad_start++;
                lat = $urandom_range(0, 4);
            end else if (core_hash_start !== 1'b0) begin
                bad_start++;
            end
            if (busy !== m_busy) bad_busy++;
            d = 1'b0;
            if (m_busy) begin
                if (lat == 0) d = 1'b1;
                else lat--;
            end
            s = '0;
            if (cyc < 550) begin
                for (int i = 0; i < N; i++) begin
                    if (!active[i] && $urandom_range(0, 2) == 0) begin
                        s[i]      = 1'b1;
                        cdata[i]  = rand_block();
                        clen[i]   = 1'($urandom_range(0, 1));
                        active[i] = 1'b1;
                        starts[i]++;
                        set_client(i, cdata[i], clen[i]);
                    end
                end
            end
            req_hash_start = s;
            core_hash_done = d;
            if (d) core_hash_data_out = fold(cdata[m_grant], clen[m_grant]);
            #1;
            exp_done = '0;
            if (m_busy && d) exp_done[m_grant] = 1'b1;
            if (req_hash_done !== exp_done) bad_done++;
            if (d && req_hash_data_out !== fold(cdata[m_grant], clen[m_grant])) bad_dig++;
            for (int i = 0; i < N; i++) if (req_hash_done[i] === 1'b1) dones[i]++;
            m_expect_start = 1'b0;
            m_wait = m_wait | s;
            if (m_busy) begin
                if (d) begin
                    m_busy         = 1'b0;
                    m_rr           = (m_grant + 1) % N;
                    active[m_grant] = 1'b0;
                end
            end else begin
                p = rr_pick(m_wait, m_rr);
                if (p >= 0) begin
                    m_busy         = 1'b1;
                    m_grant        = p;
                    m_wait[p]      = 1'b0;
                    m_expect_start = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) if (dones[i] != starts[i]) bad_cnt++;
        n_total++; if (bad_start != 0) $display("FAIL rand_grant: got %0d bad issue cycles want 0", bad_start); else n_pass++;
        n_total++; if (bad_busy != 0) $display("FAIL rand_busy: got %0d bad cycles want 0", bad_busy); else n_pass++;
        n_total++; if (bad_done != 0) $display("FAIL rand_done_route: got %0d bad cycles want 0", bad_done); else n_pass++;
        n_total++; if (bad_dig != 0) $display("FAIL rand_digest: got %0d bad digests want 0", bad_dig); else n_pass++;
        n_total++; if (bad_cnt != 0) $display("FAIL rand_done_count: got %0d/%0d done vs %0d/%0d start", dones[0], dones[1], starts[0], starts[1]); else n_pass++;
        n_total++; if (err_overrun !== 1'b0) $display("FAIL rand_no_overrun: got %b want 0", err_overrun); else n_pass++;
    endtask

    initial begin
        reset              = 1'b1;
        req_hash_start     = '0;
        req_hash_data_in   = '0;
        req_message_length = '0;
        core_hash_done     = 1'b0;
        core_hash_data_out = '0;
        test_reset();
        test_single_client();
        test_simultaneous();
        test_fairness();
        test_thash_sequence();
        test_overrun();
        test_reset_mid_hash();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sha256_arbiter.md
Name: sha256_arbiter

Overview:
- Shares one sha256 core between NUM_REQ hash clients (thash_h, thash_f, prf, L-tree/treehash controllers).
- Each client keeps its native interface (hash_start pulse, held hash_data_in/message_length, hash_done pulse, hash_data_out) and is unaware of sharing.
- Grants the core by round-robin and holds each grant for one full hash.
- Routes the completion pulse back to the owning client only.

Parameters:
- NUM_REQ, 2, number of client ports (2..8).
- KEY_LEN, 256, digest width.
- BLOCK_LEN, 1024, hash input width per request.
- GW, 3, width of grant_id; must satisfy 2^GW >= NUM_REQ.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_hash_start  in  NUM_REQ  per-client one-cycle start pulse.
- req_hash_data_in  in  NUM_REQ*BLOCK_LEN  client i occupies bits [i*BLOCK_LEN +: BLOCK_LEN]; held stable by the client from the cycle after its start until its done.
- req_message_length  in  NUM_REQ  per-client length select; same stability rule as data.
- req_hash_done  out  NUM_REQ  one-cycle done, only to the granted client.
- req_hash_data_out  out  KEY_LEN  digest broadcast to all clients (= core_hash_data_out).
- core_hash_start  out  1  start pulse to the sha256 core.
- core_hash_data_in  out  BLOCK_LEN  selected client's data.
- core_message_length  out  1  selected client's length.
- core_hash_done  in  1  done pulse from the core.
- core_hash_data_out  in  KEY_LEN  digest from the core.
- busy  out  1  high while a hash is outstanding on the core.
- grant_id  out  GW  index of the current or last granted client.
- err_overrun  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: state IDLE; pending=0; grant_id=0; rr_ptr=0; core_hash_start=0; busy=0; err_overrun=0; req_hash_done=0.
- Registers: pending[NUM_REQ-1:0]; grant_id; rr_ptr (next priority index); 2-state FSM (IDLE, WAIT).
- Requests
  - req_hash_start[i] sets pending[i].
  - Effective request vector in IDLE is pending | req_hash_start, so a start on an idle arbiter costs no extra cycle.
- IDLE, with any effective request:
  - Select the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On that edge: grant_id<=sel, clear pending[sel], core_hash_start<=1, busy<=1, go to WAIT.
  - Latency: client start at cycle t gives core_hash_start high at t+1.
- WAIT:
  - core_hash_start is high only in the first WAIT cycle.
  - On core_hash_done: return to IDLE, busy<=0, rr_ptr<=grant_id+1 mod NUM_REQ.
  - core_hash_done arriving in the same cycle as core_hash_start is accepted.
- Datapath muxes (combinational from the grant_id register; valid while busy):
  - core_hash_data_in = req_hash_data_in[grant_id].
  - core_message_length = req_message_length[grant_id].
- Done routing (combinational, same cycle as core_hash_done, so digest and done stay aligned):
  - req_hash_done[i] = core_hash_done & (state==WAIT) & (grant_id==i).
  - core_hash_done in IDLE is ignored and routes no pulse.
- Back-to-back: a client restarting in the cycle after its done competes normally. With other pending clients it waits its round-robin turn. Core idle gap between hashes is exactly 1 cycle (the IDLE cycle).
- Simultaneous starts: all are latched; served in round-robin order from rr_ptr.
- Overrun: req_hash_start[i] while pending[i]=1, or while WAIT with grant_id==i, sets err_overrun. The request is absorbed, not queued twice. err_overrun clears only on reset.
- Reset mid-hash: all state clears immediately and no done pulse is issued. The core shares the same reset, so no stale done can follow.

Decomposition:
- Shared package/include holds: BLOCK_LEN, KEY_LEN, FSM state encodings, and an rr_select function (rotating priority encoder).
- One sub-module is natural: rr_priority_enc (NUM_REQ-wide request vector + rr_ptr → sel index, any_req).

Test Plan:
- Single client: NUM_REQ=2, client0 start at cycle 10, core done at cycle 80 → core_hash_start at 11, core_hash_data_in = client0 data, req_hash_done=2'b01 at 80 only, busy high 11..80.
- Simultaneous: both start at cycle 10, rr_ptr=0 → client0 served first. Client1 core_hash_start at the cycle after client0's done +1. Grant order 0,1; rr_ptr ends at 0.
- Fairness: both clients restart immediately after every done for 20 hashes → grants strictly alternate 0,1,0,1; each gets exactly 10 done pulses.
- Full thash_h sequence (4 hashes: 3 PRF + core_hash) on client1 with client0 idle → per-hash message_length forwarded (0,0,0,1). Output digest matches the standalone thash_h golden value.
- Overrun: client0 start while pending or granted → err_overrun=1, sticky until reset; only one hash issued for client0.
- Reset at cycle 5 of a WAIT → next cycle busy=0, pending=0, no req_hash_done. A new start afterwards is served normally from grant 0.
